// File: rtl/fcvt_s_w_seq_if.sv
// Start/done handshake bundle for the sequential int32 -> binary32 converter.
// Optional build macro: FCVT_FLAGS_EN adds the inexact flag fflags_nx.
interface fcvt_s_w_seq_if;
  logic        Fcvt_en;
  logic [31:0] read_data1;
  logic [31:0] cvtdata_out;
  logic        busy;
  logic        done;
`ifdef FCVT_FLAGS_EN
  logic        fflags_nx;
`endif

  modport master (
    output Fcvt_en,
    output read_data1,
    input  cvtdata_out,
    input  busy,
    input  done
`ifdef FCVT_FLAGS_EN
    ,
    input  fflags_nx
`endif
  );

  modport slave (
    input  Fcvt_en,
    input  read_data1,
    output cvtdata_out,
    output busy,
    output done
`ifdef FCVT_FLAGS_EN
    ,
    output fflags_nx
`endif
  );
endinterface

// File: rtl/fcvt_s_w_seq.sv
// Sequential FCVT.S.W: two's-complement int32 to IEEE-754 binary32.
// Normalises one bit per cycle, then rounds to nearest-even.
// Optional build macro: FCVT_FLAGS_EN adds fflags_nx (inexact), registered with the result.
module fcvt_s_w_seq #(
  parameter int unsigned EXP_BIAS = 127
) (
  input logic           clk,
  input logic           rst,
  fcvt_s_w_seq_if.slave bus
);

  // Exponent of a value whose leading one sits at bit 31.
  localparam logic [7:0] ExpStart = 8'(EXP_BIAS + 31);

  typedef enum logic [1:0] {StIdle, StNorm, StRound} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        zero_q, zero_d;
  logic [31:0] res_q, res_d;
  logic        done_q, done_d;

  logic [22:0] frac;
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_up;
  logic        carry;
  logic [22:0] frac_rnd;
  logic [7:0]  exp_rnd;
  logic        accept;

  assign accept = (state_q == StIdle) && bus.Fcvt_en;

  // Rounding datapath: only meaningful once mag_q is normalised (ROUND state).
  always_comb begin
    frac              = mag_q[30:8];
    guard_bit         = mag_q[7];
    sticky_bit        = |mag_q[6:0];
    round_up          = guard_bit & (sticky_bit | frac[0]);
    {carry, frac_rnd} = {1'b0, frac} + 24'(round_up);
    exp_rnd           = exp_q + 8'(carry);
  end

  // Next-state and datapath updates for the IDLE -> NORM -> ROUND sequence.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.Fcvt_en) begin
          sign_d  = bus.read_data1[31];
          // 0x80000000 negates to itself, which is the correct unsigned magnitude.
          mag_d   = bus.read_data1[31] ? (~bus.read_data1 + 32'd1) : bus.read_data1;
          exp_d   = ExpStart;
          zero_d  = 1'b0;
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (mag_q == 32'd0) begin
          zero_d  = 1'b1;
          state_d = StRound;
        end else if (mag_q[31]) begin
          state_d = StRound;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      StRound: begin
        res_d   = zero_q ? 32'd0 : {sign_q, exp_rnd, frac_rnd};
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      mag_q   <= 32'd0;
      exp_q   <= 8'd0;
      zero_q  <= 1'b0;
      res_q   <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

`ifdef FCVT_FLAGS_EN
  logic nx_q;

  // Inexact flag: cleared on accept, loaded with the discarded bits at ROUND.
  always_ff @(posedge clk) begin
    if (rst) begin
      nx_q <= 1'b0;
    end else if (accept) begin
      nx_q <= 1'b0;
    end else if (state_q == StRound) begin
      nx_q <= guard_bit | sticky_bit;
    end
  end

  assign bus.fflags_nx = nx_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  assign bus.cvtdata_out = res_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_fcvt_s_w_seq.sv
// Directed bench for fcvt_s_w_seq: hand-computed binary32 results and latencies.
// Build with FCVT_FLAGS_EN defined to also check fflags_nx.
module tb_fcvt_s_w_seq;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  fcvt_s_w_seq_if bus ();

  fcvt_s_w_seq #(
    .EXP_BIAS(127)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Accept one operand, then wait (bounded) for done and check result, latency and flag.
  task automatic run_conv(input string tag, input logic [31:0] val, input logic [31:0] exp_res,
                          input int unsigned exp_lat, input logic exp_nx);
    int unsigned lat;
    lat = 0;
    bus.Fcvt_en    = 1'b1;
    bus.read_data1 = val;
    @(posedge clk); #1;
    bus.Fcvt_en    = 1'b0;
    bus.read_data1 = 32'hDEAD_BEEF;
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, bus.cvtdata_out, exp_res);
`ifdef FCVT_FLAGS_EN
    check_eq({tag, "_nx"}, 32'(bus.fflags_nx), 32'(exp_nx));
`else
    if (exp_nx === 1'bx) $display("note: %s unexpected x flag", tag);
`endif
  endtask

  // Count done pulses over a window where none should appear.
  task automatic quiet_window(input string tag);
    int unsigned pulses;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    check_eq({tag, "_nodone"}, pulses, 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.Fcvt_en    = 1'b0;
    bus.read_data1 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out", bus.cvtdata_out, 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
`ifdef FCVT_FLAGS_EN
    check_eq("rst_nx", 32'(bus.fflags_nx), 32'd0);
`endif
    rst = 1'b0;

    // Back-to-back: each call starts in the cycle done is high.
    run_conv("zero",    32'h0000_0000, 32'h0000_0000,  2, 1'b0);
    run_conv("one",     32'h0000_0001, 32'h3F80_0000, 33, 1'b0);
    run_conv("m12",     32'hFFFF_FFF4, 32'hC140_0000, 30, 1'b0);
    run_conv("minint",  32'h8000_0000, 32'hCF00_0000,  2, 1'b0);
    run_conv("maxint",  32'h7FFF_FFFF, 32'h4F00_0000,  3, 1'b1);
    run_conv("tie_even", 32'd16777217, 32'h4B80_0000,  9, 1'b1);
    run_conv("tie_up",  32'd16777219, 32'h4B80_0002,  9, 1'b1);
    run_conv("exact24", 32'd16777216, 32'h4B80_0000,  9, 1'b0);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);

    // Start while busy must be ignored.
    begin
      int unsigned lat;
      lat = 0;
      @(posedge clk); #1;
      bus.Fcvt_en    = 1'b1;
      bus.read_data1 = 32'd5;
      @(posedge clk); #1;
      bus.Fcvt_en    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.Fcvt_en    = 1'b1;
      bus.read_data1 = 32'd7;
      @(posedge clk); #1;
      bus.Fcvt_en    = 1'b0;
      for (int n = 5; n <= 40; n++) begin
        @(posedge clk); #1;
        if (bus.done) begin
          lat = n;
          break;
        end
      end
      check_eq("ign_lat", lat, 32'd31);
      check_eq("ign_res", bus.cvtdata_out, 32'h40A0_0000);
      quiet_window("ign");
      check_eq("ign_hold", bus.cvtdata_out, 32'h40A0_0000);
    end

    // Reset mid-conversion aborts without a done pulse.
    bus.Fcvt_en    = 1'b1;
    bus.read_data1 = 32'd1;
    @(posedge clk); #1;
    bus.Fcvt_en    = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_out", bus.cvtdata_out, 32'd0);
    rst = 1'b0;
    quiet_window("abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
